// File: rtl/output_collector.sv
// Output collector for an N x N systolic array: gathers N result words per column
// from the bottom-edge PEs into an N*N buffer, then drains them as one
// valid/ready stream in address order (column c, element k at c*N+k).
// Ports: clk_i/rstn_i clock and async active-low reset; start_i arms a collection;
//   col_data_i/col_valid_i/col_last_i per-column result strobes; m_data_o/m_valid_o/
//   m_ready_i/m_last_o drain stream; busy_o, done_o (1-cycle pulse), error_o (sticky).
// Drain latency: first word valid one cycle after entering DRAIN; one word/cycle
// under constant ready; outputs hold while m_valid_o=1 and m_ready_i=0.
module output_collector #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           start_i,
  input  logic [N-1:0][DATA_WIDTH-1:0]   col_data_i,
  input  logic [N-1:0]                   col_valid_i,
  input  logic [N-1:0]                   col_last_i,
  output logic [DATA_WIDTH-1:0]          m_data_o,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic                           m_last_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           error_o
);

  localparam int NN = N * N;
  localparam int CW = $clog2(N + 1);
  localparam int AW = $clog2(NN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [N-1:0][CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]              addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      data_q, data_d;
  logic                       vld_q, vld_d;
  logic                       last_q, last_d;
  logic                       err_q, err_d;
  logic [N-1:0]               wr_en;
  logic                       all_full;

  // Result buffer: deliberately not reset, every entry is rewritten before a drain.
  logic [DATA_WIDTH-1:0]      mem [NN];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    vld_d    = vld_q;
    last_d   = last_q;
    err_d    = err_q;
    wr_en    = '0;
    all_full = 1'b1;
    for (int c = 0; c < N; c++) begin
      if (cnt_q[c] != CW'(N)) all_full = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = COLLECT;
          cnt_d   = '0;
          addr_d  = '0;
          vld_d   = 1'b0;
          last_d  = 1'b0;
          err_d   = 1'b0;
        end
      end

      COLLECT: begin
        // Writes are still checked in the cycle the buffer reads full, so a
        // late extra strobe there is flagged rather than silently lost.
        for (int c = 0; c < N; c++) begin
          if (col_valid_i[c]) begin
            if (cnt_q[c] < CW'(N)) begin
              wr_en[c] = 1'b1;
              cnt_d[c] = cnt_q[c] + CW'(1);
              if (col_last_i[c] && (cnt_q[c] != CW'(N - 1))) err_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        if (all_full) begin
          state_d = DRAIN;
          addr_d  = '0;
        end
      end

      DRAIN: begin
        if (vld_q && m_ready_i && last_q) begin
          state_d = DONE;
          vld_d   = 1'b0;
          last_d  = 1'b0;
        end else if (!vld_q || m_ready_i) begin
          // Output slot empty or being consumed: refill from the buffer so a
          // handshake is followed by the next word without a bubble.
          data_d = mem[addr_q];
          vld_d  = 1'b1;
          last_d = (addr_q == AW'(NN - 1));
          if (addr_q != AW'(NN - 1)) addr_d = addr_q + AW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < N; c++) begin
      if (wr_en[c]) mem[AW'(c * N) + AW'(cnt_q[c])] <= col_data_i[c];
    end
  end

  assign m_data_o  = data_q;
  assign m_valid_o = vld_q;
  assign m_last_o  = last_q;
  assign busy_o    = (state_q == COLLECT) || (state_q == DRAIN);
  assign done_o    = (state_q == DONE);
  assign error_o   = err_q;

endmodule
